imem_loader: RTL

//  Writer side of the instruction memory. Receives a framed byte stream and writes
//  32-bit words into the instruction memory write port, starting at word 0.

---
 rtl/imem_loader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Writer side of the instruction memory. Parses a framed byte
//               stream (LEN_LO, LEN_HI, LEN little-endian 32-bit words,
//               CSUM = XOR of all preceding bytes) and writes the words to the
//               instruction memory starting at word 0. The core is held in
//               reset until a complete frame with a good checksum is loaded.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start               - re-arm pulse, honoured in DONE/ERR only
//               in_data/in_valid/in_ready - byte stream handshake
//               imem_we/imem_addr/imem_wdata - memory write port
//               core_rst_n          - core reset (active-low), 1 only in DONE
//               done/error          - load status
//               words_loaded        - words written in the current frame
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // Largest legal word count is the full memory capacity.
    localparam logic [16:0] c_max_len      = 17'd1 << ADDR_W;
    localparam logic        c_timeout_en   = (TIMEOUT_CYC > 0);
    localparam logic [31:0] c_timeout_last = (TIMEOUT_CYC > 0) ? 32'(TIMEOUT_CYC - 1) : 32'd0;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_len;
    logic [7:0]        r_csum;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_acc;
    logic [31:0]       r_timer;
    logic [15:0]       r_words;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              w_ready;
    logic              w_accept;
    logic              w_timed;
    logic              w_timeout;
    logic [15:0]       w_len;
    logic              w_last_byte;
    logic              w_last_word;

    assign w_ready     = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                         (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_accept    = in_valid & w_ready;
    assign w_timed     = (r_state == S_LEN1) || (r_state == S_DATA) || (r_state == S_CSUM);
    // Fires on the edge that would take the idle count to TIMEOUT_CYC.
    assign w_timeout   = c_timeout_en && w_timed && !w_accept && (r_timer == c_timeout_last);
    assign w_len       = {in_data, r_len[7:0]};
    assign w_last_byte = (r_byte_idx == 2'd3);
    assign w_last_word = ((r_words + 16'd1) == r_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LEN0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LEN0: begin
                if (w_accept) w_state_nxt = S_LEN1;
            end
            S_LEN1: begin
                if (w_accept) begin
                    if ({1'b0, w_len} > c_max_len) w_state_nxt = S_ERR;
                    else if (w_len == 16'd0)       w_state_nxt = S_CSUM;
                    else                           w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept && w_last_byte && w_last_word) w_state_nxt = S_CSUM;
            end
            S_CSUM: begin
                if (w_accept) w_state_nxt = (in_data == r_csum) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (start) w_state_nxt = S_LEN0;
            end
            default: w_state_nxt = S_ERR;
        endcase
        if (w_timeout) w_state_nxt = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= 16'd0;
            r_csum     <= 8'd0;
            r_byte_idx <= 2'd0;
            r_acc      <= 32'd0;
            r_timer    <= 32'd0;
            r_words    <= 16'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
        end else begin
            r_we <= 1'b0;

            if (w_accept) begin
                r_timer <= 32'd0;
            end else if (w_timed && c_timeout_en) begin
                r_timer <= r_timer + 32'd1;
            end

            case (r_state)
                S_LEN0: begin
                    if (w_accept) begin
                        r_len[7:0] <= in_data;
                        r_csum     <= r_csum ^ in_data;
                    end
                end
                S_LEN1: begin
                    if (w_accept) begin
                        r_len[15:8] <= in_data;
                        r_csum      <= r_csum ^ in_data;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_csum     <= r_csum ^ in_data;
                        // New bytes enter at the top so byte0 ends up in [7:0].
                        r_acc      <= {in_data, r_acc[31:8]};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_last_byte) begin
                            r_wdata <= {in_data, r_acc[31:8]};
                            r_addr  <= r_words[ADDR_W-1:0];
                            r_we    <= 1'b1;
                            r_words <= r_words + 16'd1;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (start) begin
                        r_words    <= 16'd0;
                        r_csum     <= 8'd0;
                        r_byte_idx <= 2'd0;
                        r_timer    <= 32'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready     = w_ready;
    assign imem_we      = r_we;
    assign imem_addr    = r_addr;
    assign imem_wdata   = r_wdata;
    assign core_rst_n   = (r_state == S_DONE);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERR);
    assign words_loaded = r_words;

endmodule
`default_nettype wire
